// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 fetch stage: jump opcodes, FSM state type
// and the jump-decision helper.
package td4_pkg;

   localparam logic [3:0] OP_JMP = 4'b1111;
   localparam logic [3:0] OP_JNC = 4'b1110;
   localparam int         PC_W   = 4;
   localparam int         CNT_W  = 5;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // True when the instruction redirects the program counter to imm.
   function automatic logic take_jump(input logic [3:0] opcode, input logic carry);
      return (opcode == OP_JMP) || ((opcode == OP_JNC) && !carry);
   endfunction

endpackage

// File: rtl/td4_fetch_if.sv
// Host program-byte stream into the fetch unit.
// Handshake: a byte transfers on a rising edge where prog_valid and prog_ready are both 1.
// prog_last is only meaningful while prog_valid is 1.
interface td4_fetch_if;

   logic       prog_valid;
   logic [7:0] prog_data;
   logic       prog_last;
   logic       prog_ready;

   modport master (output prog_valid, prog_data, prog_last, input prog_ready);
   modport slave  (input prog_valid, prog_data, prog_last, output prog_ready);

endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 program memory: synchronous write, asynchronous read, optional async clear.
module td4_prog_mem #(
   parameter int MEM_WORDS      = 16,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [MEM_WORDS];

   generate
      if (CLEAR_ON_RESET) begin : g_clear
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < MEM_WORDS; i++) begin
                  mem[i] <= 8'h00;
               end
            end else if (we) begin
               mem[waddr] <= wdata;
            end
         end
      end else begin : g_keep
         // Contents survive reset; only the fetch FSM is reinitialised.
         always_ff @(posedge clk) begin
            if (we) begin
               mem[waddr] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = mem[raddr];

endmodule

// File: rtl/td4_fetch.sv
// TD4 fetch unit: loads a program from a host byte stream, then serves
// instructions at the current pc and decides jump loads for the counter.
module td4_fetch
   import td4_pkg::*;
#(
   parameter int MEM_WORDS      = 16,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    pc,
   input  logic               carry,
   td4_fetch_if.slave         prog,
   input  logic               reload,
   output logic               run,
   output logic [7:0]         instr,
   output logic [3:0]         opcode,
   output logic [3:0]         imm,
   output logic               pc_ld_n,
   output logic [CNT_W-1:0]   load_cnt,
   output fetch_state_t       state
);

   fetch_state_t           state_q, state_d;
   logic [PC_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]       load_cnt_q, load_cnt_d;
   logic                   we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD;
         wr_ptr_q   <= '0;
         load_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         load_cnt_q <= load_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      load_cnt_d = load_cnt_q;
      we         = 1'b0;
      case (state_q)
         LOAD: begin
            // reload has priority over a byte offered in the same cycle
            if (reload) begin
               wr_ptr_d   = '0;
               load_cnt_d = '0;
            end else if (prog.prog_valid) begin
               we         = 1'b1;
               load_cnt_d = load_cnt_q + 5'd1;
               if (prog.prog_last || (wr_ptr_q == 4'd15)) begin
                  state_d  = RUN;
                  wr_ptr_d = '0;
               end else begin
                  wr_ptr_d = wr_ptr_q + 4'd1;
               end
            end
         end
         RUN: begin
            if (reload) begin
               state_d    = LOAD;
               wr_ptr_d   = '0;
               load_cnt_d = '0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   td4_prog_mem #(
      .MEM_WORDS      (MEM_WORDS),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (prog.prog_data),
      .raddr (pc),
      .rdata (instr)
   );

   assign opcode          = instr[7:4];
   assign imm             = instr[3:0];
   assign run             = (state_q == RUN);
   assign prog.prog_ready = (state_q == LOAD);
   assign pc_ld_n         = !(run && take_jump(opcode, carry));
   assign load_cnt        = load_cnt_q;
   assign state           = state_q;

endmodule

// File: tb/tb_td4_fetch.sv
// Directed bench for td4_fetch: program loads, reloads, resets and jump decode,
// checked through an expected-value scoreboard.
module tb_td4_fetch;
   import td4_pkg::*;

   localparam int K_INSTR = 0, K_RUN = 1, K_READY = 2, K_LDN = 3,
                  K_CNT = 4, K_IMM = 5, K_OPC = 6, K_STATE = 7;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [3:0]   pc = 4'd0;
   logic         carry = 1'b0;
   logic         reload = 1'b0;
   logic         run;
   logic [7:0]   instr;
   logic [3:0]   opcode, imm;
   logic         pc_ld_n;
   logic [4:0]   load_cnt;
   fetch_state_t state;

   td4_fetch_if prog_bus ();

   td4_fetch #(.MEM_WORDS(16), .CLEAR_ON_RESET(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .pc       (pc),
      .carry    (carry),
      .prog     (prog_bus),
      .reload   (reload),
      .run      (run),
      .instr    (instr),
      .opcode   (opcode),
      .imm      (imm),
      .pc_ld_n  (pc_ld_n),
      .load_cnt (load_cnt),
      .state    (state)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   int         kind_q[$];
   string      name_q[$];
   event       probe_ev;
   int         total = 0;
   int         bad = 0;

   function automatic logic [7:0] actual_of(input int kind);
      case (kind)
         K_INSTR: return instr;
         K_RUN:   return {7'd0, run};
         K_READY: return {7'd0, prog_bus.prog_ready};
         K_LDN:   return {7'd0, pc_ld_n};
         K_CNT:   return {3'd0, load_cnt};
         K_IMM:   return {4'd0, imm};
         K_OPC:   return {4'd0, opcode};
         default: return {7'd0, state};
      endcase
   endfunction

   always @(probe_ev) begin
      while (exp_q.size() > 0) begin
         logic [7:0] e, a;
         int         k;
         string      n;
         e = exp_q.pop_front();
         k = kind_q.pop_front();
         n = name_q.pop_front();
         a = actual_of(k);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
         end
      end
   end

   task automatic chk(input int kind, input logic [7:0] e, input string n);
      exp_q.push_back(e);
      kind_q.push_back(kind);
      name_q.push_back(n);
      -> probe_ev;
      #1;
   endtask

   task automatic read_mem(input logic [3:0] a, input logic [7:0] e, input string n);
      pc = a;
      #1;
      chk(K_INSTR, e, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      pc = 4'd0;
      reset = 1'b1;
      #2;
      chk(K_STATE, 8'(LOAD), "rst_state");
      chk(K_RUN, 8'd0, "rst_run");
      chk(K_READY, 8'd1, "rst_ready");
      chk(K_CNT, 8'd0, "rst_cnt");
      chk(K_INSTR, 8'h00, "rst_instr");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      @(negedge clk);
      prog_bus.prog_valid = 1'b1;
      prog_bus.prog_data  = d;
      prog_bus.prog_last  = last;
      @(posedge clk);
      #1;
      prog_bus.prog_valid = 1'b0;
      prog_bus.prog_last  = 1'b0;
   endtask

   task automatic pulse_reload(input logic with_byte, input logic [7:0] d);
      @(negedge clk);
      reload = 1'b1;
      prog_bus.prog_valid = with_byte;
      prog_bus.prog_data  = d;
      @(posedge clk);
      #1;
      reload = 1'b0;
      prog_bus.prog_valid = 1'b0;
   endtask

   initial begin
      prog_bus.prog_valid = 1'b0;
      prog_bus.prog_data  = 8'h00;
      prog_bus.prog_last  = 1'b0;

      do_reset();

      // full 16-byte load exits on wr_ptr=15 without prog_last
      for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i), 1'b0);
      chk(K_RUN, 8'd0, "full_run_b15");
      chk(K_CNT, 8'd15, "full_cnt_b15");
      send_byte(8'h1F, 1'b0);
      chk(K_RUN, 8'd1, "full_run_b16");
      chk(K_READY, 8'd0, "full_ready");
      chk(K_CNT, 8'd16, "full_cnt");
      read_mem(4'd5, 8'h15, "full_mem5");
      read_mem(4'd15, 8'h1F, "full_mem15");
      read_mem(4'd0, 8'h10, "full_mem0");

      // reload keeps untouched words
      pulse_reload(1'b0, 8'h00);
      chk(K_STATE, 8'(LOAD), "rl_state");
      chk(K_CNT, 8'd0, "rl_cnt");
      chk(K_RUN, 8'd0, "rl_run");
      send_byte(8'hAA, 1'b1);
      chk(K_RUN, 8'd1, "rl_run_after");
      chk(K_CNT, 8'd1, "rl_cnt_after");
      read_mem(4'd0, 8'hAA, "rl_mem0");
      read_mem(4'd1, 8'h11, "rl_mem1");
      read_mem(4'd15, 8'h1F, "rl_mem15");

      // jump decode
      pulse_reload(1'b0, 8'h00);
      send_byte(8'hF7, 1'b0);
      send_byte(8'hE2, 1'b0);
      send_byte(8'h33, 1'b1);
      read_mem(4'd0, 8'hF7, "jmp_instr");
      chk(K_LDN, 8'd0, "jmp_ldn");
      chk(K_IMM, 8'd7, "jmp_imm");
      chk(K_OPC, 8'hF, "jmp_opc");
      carry = 1'b1;
      read_mem(4'd1, 8'hE2, "jnc_instr");
      chk(K_LDN, 8'd1, "jnc_c1_ldn");
      carry = 1'b0;
      #1;
      chk(K_LDN, 8'd0, "jnc_c0_ldn");
      chk(K_IMM, 8'd2, "jnc_imm");
      read_mem(4'd2, 8'h33, "nojmp_instr");
      chk(K_LDN, 8'd1, "nojmp_ldn");

      // CPU held in LOAD even with a JMP at pc
      pulse_reload(1'b0, 8'h00);
      read_mem(4'd0, 8'hF7, "load_jmp_instr");
      chk(K_LDN, 8'd1, "load_ldn");
      chk(K_RUN, 8'd0, "load_run");

      // reload and byte in the same LOAD cycle: byte dropped
      send_byte(8'h44, 1'b0);
      chk(K_CNT, 8'd1, "pre_coll_cnt");
      pulse_reload(1'b1, 8'h55);
      chk(K_CNT, 8'd0, "coll_cnt");
      chk(K_STATE, 8'(LOAD), "coll_state");
      read_mem(4'd0, 8'h44, "coll_mem0");
      read_mem(4'd1, 8'hE2, "coll_mem1");

      // reset mid-load
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(8'h21 + 8'(i), 1'b0);
      chk(K_CNT, 8'd5, "mid_cnt5");
      do_reset();
      for (int i = 0; i < 16; i++) read_mem(4'(i), 8'h00, "mid_clear");
      send_byte(8'h9A, 1'b1);
      read_mem(4'd0, 8'h9A, "mid_next_mem0");
      chk(K_CNT, 8'd1, "mid_next_cnt");

      // short load with prog_last
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      chk(K_RUN, 8'd0, "short_run_b2");
      send_byte(8'h83, 1'b1);
      chk(K_RUN, 8'd1, "short_run");
      chk(K_CNT, 8'd3, "short_cnt");
      read_mem(4'd2, 8'h83, "short_mem2");
      for (int i = 3; i < 16; i++) read_mem(4'(i), 8'h00, "short_tail");

      // RUN ignores prog_valid
      send_byte(8'h77, 1'b0);
      chk(K_CNT, 8'd3, "run_ign_cnt");
      read_mem(4'd0, 8'h01, "run_ign_mem0");

      #5;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/td4_fetch.md
TD4_FETCH -- requirements
Module: td4_fetch

Interface
REQ-001 Parameter: MEM_WORDS, 16, program memory depth; fixed at 16, matching the 4-bit program counter.
REQ-002 Parameter: CLEAR_ON_RESET, 1, when 1 reset clears every memory word to 8'h00.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 pc  in  4  program counter value from the counter stage.
REQ-006 carry  in  1  ALU carry flag, used for JNC.
REQ-007 prog_valid  in  1  host program byte valid.
REQ-008 prog_data  in  8  host program byte.
REQ-009 prog_last  in  1  marks the final byte of a program (qualified by prog_valid).
REQ-010 prog_ready  out  1  fetch unit accepts a program byte.
REQ-011 reload  in  1  single-cycle request to re-enter LOAD.
REQ-012 run  out  1  CPU enable, high only in RUN.
REQ-013 instr  out  8  instruction word at mem[pc].
REQ-014 opcode  out  4  instr[7:4].
REQ-015 imm  out  4  instr[3:0]; this is also the jump target for the counter's in port.
REQ-016 pc_ld_n  out  1  active-low counter load.
REQ-017 load_cnt  out  5  number of bytes written in the current or most recent load (0-16).

Function
REQ-018 The FSM shall have two states: LOAD and RUN.
REQ-019 In LOAD, prog_ready shall be 1, and each cycle with prog_valid=1 shall write prog_data to mem[wr_ptr], then increment wr_ptr and load_cnt.
REQ-020 An accepted byte with prog_last=1 or wr_ptr=15 shall move the FSM to RUN on the same edge and clear wr_ptr to 0.
REQ-021 wr_ptr is 4 bits; it shall never wrap within a load because wr_ptr=15 forces the exit.
REQ-022 In RUN, prog_ready shall be 0 and prog_valid shall be ignored.
REQ-023 reload=1 in RUN shall move the FSM to LOAD on the next edge, with wr_ptr=0 and load_cnt=0.
REQ-024 On reload, memory contents shall be retained; words not rewritten keep their old values.
REQ-025 reload in LOAD shall restart the load: wr_ptr=0 and load_cnt=0.
REQ-026 If reload and an accepted byte coincide in LOAD, reload wins and the byte is discarded.
REQ-027 instr shall be a combinational read of mem[pc], zero added latency, in both states.
REQ-028 In RUN, pc_ld_n shall be 0 when opcode=4'b1111 (JMP).
REQ-029 In RUN, pc_ld_n shall be 0 when opcode=4'b1110 (JNC) and carry=0.
REQ-030 In every other case pc_ld_n shall be 1.
REQ-031 In LOAD, pc_ld_n shall be 1 and run shall be 0; the CPU is held.

Reset
REQ-032 Reset shall force state=LOAD, wr_ptr=0, load_cnt=0, prog_ready=1, run=0.
REQ-033 With CLEAR_ON_RESET=1, reset shall set every mem word to 8'h00, so instr=8'h00 immediately.
REQ-034 Reset mid-load shall discard the partial load; the next accepted byte writes mem[0].

Structure
REQ-035 A shared package td4_pkg shall hold the opcode localparams (OP_JMP=4'b1111, OP_JNC=4'b1110) and the state enum fetch_state_t {LOAD, RUN}.
REQ-036 A single sub-module td4_prog_mem shall implement the 16x8 memory: one synchronous write port, one asynchronous read port, async clear.

Verification
REQ-037 Reset, then stream 16 bytes 8'h10..8'h1F without prog_last -> run=1 after byte 16, load_cnt=16, pc=5 gives instr=8'h15.
REQ-038 Load 3 bytes with prog_last on the third -> RUN after 3 bytes, load_cnt=3, mem[3..15]=8'h00.
REQ-039 In RUN, instr=8'hF7 -> pc_ld_n=0, imm=7; instr=8'hE2 with carry=1 -> pc_ld_n=1; with carry=0 -> pc_ld_n=0.
REQ-040 Assert reload in RUN, then load 1 byte 8'hAA -> mem[0]=8'hAA, mem[1..15] unchanged.
REQ-041 Assert reset after 5 bytes accepted -> state LOAD, load_cnt=0, all instr reads 8'h00.
REQ-042 Same-cycle reload and prog_valid in LOAD -> byte not written, load_cnt=0.
